data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 5: cycles from request acceptance to completion, legal range 1..15.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port READ, input, 1 bit: CPU read request, held until BUSYWAIT falls.
REQ-005 The block SHALL have port WRITE, input, 1 bit: CPU write request, held until BUSYWAIT falls.
REQ-006 The block SHALL have port ADDRESS, input, 8 bits: byte address into 256 x 8-bit storage.
REQ-007 The block SHALL have port WRITEDATA, input, 8 bits: data to store on a write.
REQ-008 The block SHALL have port READDATA, output, 8 bits: data returned by the last completed read, registered.
REQ-009 The block SHALL have port BUSYWAIT, output, 1 bit: stall signal to the CPU.

Function
REQ-010 Storage SHALL be 256 entries x 8 bits, indexed directly by ADDRESS, with no wrap or aliasing.
REQ-011 The block SHALL implement states IDLE, BUSY and DONE.
REQ-012 In IDLE, BUSYWAIT SHALL equal (READ | WRITE) combinationally, so the CPU stalls in the same cycle it issues a request.
REQ-013 At a rising edge in IDLE with READ or WRITE high, the block SHALL latch ADDRESS, WRITEDATA and the operation, load a 4-bit down-counter with MEM_LATENCY-1, and enter BUSY.
REQ-014 If READ and WRITE are both high at acceptance, the block SHALL perform a write and ignore the read.
REQ-015 In BUSY, BUSYWAIT SHALL be 1, and the counter SHALL decrement by 1 at each rising edge while non-zero.
REQ-016 At the rising edge in BUSY where the counter is 0, the latched operation SHALL complete and the state SHALL become DONE:
- write: latched data stored at the latched address
- read: storage at the latched address loaded into READDATA
REQ-017 Completion SHALL occur exactly MEM_LATENCY edges after the acceptance edge.
REQ-018 In DONE, BUSYWAIT SHALL be 0 for exactly one cycle, and the next edge SHALL return the state to IDLE unconditionally; a request present in DONE SHALL NOT be accepted.
REQ-019 Changes on READ, WRITE, ADDRESS or WRITEDATA during BUSY SHALL be ignored, and an operation whose request drops mid-BUSY SHALL still complete.
REQ-020 READDATA SHALL change only on read completion or reset, and SHALL hold its value through writes and idle cycles.
REQ-021 A read of an address written by an earlier completed write SHALL return that write's data.

Reset
REQ-022 While RESET is high, asynchronously:
- state SHALL be IDLE
- counter SHALL be 0
- READDATA SHALL be 8'h00
- BUSYWAIT SHALL be 0 regardless of READ/WRITE
REQ-023 A RESET asserted mid-BUSY SHALL abort the operation, with no storage write and no READDATA update.
REQ-024 After RESET deasserts, a held request SHALL be accepted at the first rising edge.

Configuration
REQ-025 With macro DMEM_CLEAR_ON_RESET_EN defined, RESET SHALL clear all 256 storage entries to 8'h00; without it, storage contents SHALL be retained across reset and are X from power-up until written.

Verification
REQ-026 The bench SHALL cover a write then read: write 8'hA5 to address 8'h10, then read 8'h10 -> BUSYWAIT high for 6 cycles per access (IDLE cycle plus 5 BUSY cycles, low in DONE), READDATA=8'hA5 after the 5th edge of the read.
REQ-027 The bench SHALL cover READ=WRITE=1: with address 8'h20 and data 8'h3C -> write performed, READDATA unchanged, a later read of 8'h20 returns 8'h3C.
REQ-028 The bench SHALL cover mid-BUSY input changes: ADDRESS changed to 8'hFF and READ dropped at the 2nd BUSY edge -> read of the original address still completes with the correct data.
REQ-029 The bench SHALL cover reset mid-write: RESET pulsed during BUSY of a write of 8'h77 to 8'h05 -> BUSYWAIT=0 immediately, address 8'h05 not written, READDATA=8'h00.
REQ-030 The bench SHALL cover MEM_LATENCY=1: a read accepted at edge N -> READDATA valid after edge N+1 and BUSYWAIT low in the following cycle.
REQ-031 The bench SHALL cover DMEM_CLEAR_ON_RESET_EN: write 8'h11 to 8'hFF, then reset, then read 8'hFF -> 8'h00 with the macro defined, 8'h11 without it.

Source files
------------

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : 256 x 8-bit data memory with a fixed multi-cycle access
//               latency and a BUSYWAIT stall handshake. A request is accepted
//               in IDLE, counted down in BUSY, completed on the last BUSY edge,
//               and followed by a one-cycle DONE in which BUSYWAIT is low.
//               Optional macro DMEM_CLEAR_ON_RESET_EN clears all storage on
//               RESET; without it storage is retained across reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
  parameter int MEM_LATENCY = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       READ,
  input  logic       WRITE,
  input  logic [7:0] ADDRESS,
  input  logic [7:0] WRITEDATA,
  output logic [7:0] READDATA,
  output logic       BUSYWAIT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter start value: completion lands MEM_LATENCY edges after acceptance.
  localparam logic [3:0] LOAD_COUNT = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wr_op_q, wr_op_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        busy_w;

  logic [7:0]  mem [256];

  assign mem_rdata = mem[addr_q];

  // Next-state logic: accept in IDLE, count down in BUSY, complete at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_op_d = wr_op_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (READ || WRITE) begin
          addr_d  = ADDRESS;
          wdata_d = WRITEDATA;
          // A simultaneous read+write resolves to a write.
          wr_op_d = WRITE;
          cnt_d   = LOAD_COUNT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          if (wr_op_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_rdata;
          end
        end
      end
      ST_DONE: begin
        // Requests seen here are deliberately not accepted.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stall: follows the request in IDLE so the CPU stalls in its issue cycle.
  always_comb begin
    busy_w = 1'b0;
    if (!RESET) begin
      case (state_q)
        ST_IDLE: busy_w = READ | WRITE;
        ST_BUSY: busy_w = 1'b1;
        default: busy_w = 1'b0;
      endcase
    end
  end

  // Control and read-data registers; reset aborts any in-flight access.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      wr_op_q <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_op_q <= wr_op_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  // Storage array, cleared to zero whenever RESET is asserted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end
`else
  // Storage array, retained across reset; writes are blocked while in reset.
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) begin
      mem[addr_q] <= wdata_q;
    end
  end
`endif

  assign READDATA = rdata_q;
  assign BUSYWAIT = busy_w;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Self-checking bench for data_memory. A default-latency
//               instance carries the directed and random scenarios against an
//               array-based reference model; a MEM_LATENCY=1 instance covers
//               the minimum-latency timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

  logic       clk = 1'b0;
  logic       RESET;
  logic       READ, WRITE;
  logic [7:0] ADDRESS, WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;

  logic       rd1, wr1;
  logic [7:0] addr1, wd1;
  logic [7:0] rdata1;
  logic       busy1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain array plus a "known" flag per byte.
  logic [7:0] model_mem [256];
  bit         model_valid [256];
  logic [7:0] model_rd;
  logic [7:0] model_rd1;
  logic [7:0] written_q [$];

  always #5 clk = ~clk;

  data_memory #(.MEM_LATENCY(5)) dut (
    .CLK(clk), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
    .READDATA(READDATA), .BUSYWAIT(BUSYWAIT)
  );

  data_memory #(.MEM_LATENCY(1)) dut1 (
    .CLK(clk), .RESET(RESET), .READ(rd1), .WRITE(wr1),
    .ADDRESS(addr1), .WRITEDATA(wd1),
    .READDATA(rdata1), .BUSYWAIT(busy1)
  );

  // Model effect of a completed access (write wins over read).
  task automatic model_apply(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    if (wr) begin
      model_mem[a]   = d;
      model_valid[a] = 1'b1;
      written_q.push_back(a);
    end else if (rd) begin
      model_rd = model_mem[a];
    end
  endtask

  // Model effect of a reset.
  task automatic model_reset();
    model_rd  = 8'h00;
    model_rd1 = 8'h00;
`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 256; i++) begin
      model_mem[i]   = 8'h00;
      model_valid[i] = 1'b1;
    end
`endif
  endtask

  // Count stall cycles from the current sample point until BUSYWAIT falls.
  task automatic run_until_done(input bit drop, output int hi, output logic [7:0] rd_last_busy);
    hi = 0;
    rd_last_busy = READDATA;
    while (BUSYWAIT === 1'b1 && hi < 40) begin
      rd_last_busy = READDATA;
      hi++;
      @(negedge clk); #1;
    end
    if (hi >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL busywait_timeout: BUSYWAIT still high after %0d cycles, required to fall", hi);
    end
    if (drop) begin
      READ  = 1'b0;
      WRITE = 1'b0;
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output int hi, output logic [7:0] rd_last_busy);
    @(negedge clk);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    #1;
    run_until_done(1'b1, hi, rd_last_busy);
  endtask

  task automatic test_reset();
    int hi;
    logic [7:0] rlb;
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b1; ADDRESS = 8'h05; WRITEDATA = 8'h5A;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 8'h00; wd1 = 8'h00;
    model_reset();
    #1;
    n_checks++;
    if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_busywait: got %b, required 0", BUSYWAIT); end
    n_checks++;
    if (READDATA !== 8'h00) begin n_fail++; $display("FAIL reset_readdata: got %h, required 00", READDATA); end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_held_busywait: got %b, required 0", BUSYWAIT); end
    // Held write request must be accepted at the first edge after release.
    READ = 1'b0;
    RESET = 1'b0;
    #1;
    run_until_done(1'b1, hi, rlb);
    model_apply(1'b0, 1'b1, 8'h05, 8'h5A);
    n_checks++;
    if (hi != 6) begin n_fail++; $display("FAIL reset_release_accept: stall cycles %0d, required 6", hi); end
    n_checks++;
    if (READDATA !== model_rd) begin n_fail++; $display("FAIL reset_release_readdata: got %h, required %h", READDATA, model_rd); end
  endtask

  task automatic test_write_read();
    int hi;
    logic [7:0] rlb;
    access(1'b0, 1'b1, 8'h10, 8'hA5, hi, rlb);
    model_apply(1'b0, 1'b1, 8'h10, 8'hA5);
    n_checks++;
    if (hi != 6) begin n_fail++; $display("FAIL wr_stall: got %0d cycles, required 6", hi); end
    n_checks++;
    if (READDATA !== model_rd) begin n_fail++; $display("FAIL wr_readdata_hold: got %h, required %h", READDATA, model_rd); end
    access(1'b1, 1'b0, 8'h10, 8'h00, hi, rlb);
    n_checks++;
    if (rlb !== model_rd) begin n_fail++; $display("FAIL rd_early_update: got %h before completion, required %h", rlb, model_rd); end
    model_apply(1'b1, 1'b0, 8'h10, 8'h00);
    n_checks++;
    if (hi != 6) begin n_fail++; $display("FAIL rd_stall: got %0d cycles, required 6", hi); end
    n_checks++;
    if (READDATA !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h, required a5", READDATA); end
  endtask

  task automatic test_both();
    int hi;
    logic [7:0] rlb;
    access(1'b1, 1'b1, 8'h20, 8'h3C, hi, rlb);
    model_apply(1'b1, 1'b1, 8'h20, 8'h3C);
    n_checks++;
    if (READDATA !== model_rd) begin n_fail++; $display("FAIL both_readdata: got %h, required %h", READDATA, model_rd); end
    access(1'b1, 1'b0, 8'h20, 8'h00, hi, rlb);
    model_apply(1'b1, 1'b0, 8'h20, 8'h00);
    n_checks++;
    if (READDATA !== 8'h3C) begin n_fail++; $display("FAIL both_write_done: got %h, required 3c", READDATA); end
  endtask

  task automatic test_mid_busy();
    int hi;
    logic [7:0] rlb;
    access(1'b0, 1'b1, 8'h30, 8'h42, hi, rlb);
    model_apply(1'b0, 1'b1, 8'h30, 8'h42);
    access(1'b0, 1'b1, 8'hFF, 8'h99, hi, rlb);
    model_apply(1'b0, 1'b1, 8'hFF, 8'h99);
    @(negedge clk);
    READ = 1'b1; ADDRESS = 8'h30;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ADDRESS = 8'hFF; READ = 1'b0;
    #1;
    run_until_done(1'b1, hi, rlb);
    model_apply(1'b1, 1'b0, 8'h30, 8'h00);
    n_checks++;
    if (hi != 4) begin n_fail++; $display("FAIL midbusy_stall: got %0d remaining cycles, required 4", hi); end
    n_checks++;
    if (READDATA !== model_rd) begin n_fail++; $display("FAIL midbusy_data: got %h, required %h", READDATA, model_rd); end
  endtask

  task automatic test_reset_mid_write();
    int hi;
    logic [7:0] rlb;
    @(negedge clk);
    WRITE = 1'b1; ADDRESS = 8'h05; WRITEDATA = 8'h77;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    RESET = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL rstmid_busywait: got %b, required 0", BUSYWAIT); end
    n_checks++;
    if (READDATA !== 8'h00) begin n_fail++; $display("FAIL rstmid_readdata: got %h, required 00", READDATA); end
    WRITE = 1'b0;
    @(negedge clk);
    RESET = 1'b0;
    access(1'b1, 1'b0, 8'h05, 8'h00, hi, rlb);
    model_apply(1'b1, 1'b0, 8'h05, 8'h00);
    n_checks++;
    if (READDATA !== model_rd) begin n_fail++; $display("FAIL rstmid_nowrite: got %h, required %h", READDATA, model_rd); end
  endtask

  task automatic test_clear_on_reset();
    int hi;
    logic [7:0] rlb;
    access(1'b0, 1'b1, 8'hFF, 8'h11, hi, rlb);
    model_apply(1'b0, 1'b1, 8'hFF, 8'h11);
    @(negedge clk);
    RESET = 1'b1;
    model_reset();
    @(negedge clk);
    RESET = 1'b0;
    access(1'b1, 1'b0, 8'hFF, 8'h00, hi, rlb);
    model_apply(1'b1, 1'b0, 8'hFF, 8'h00);
    n_checks++;
    if (READDATA !== model_rd) begin n_fail++; $display("FAIL clear_on_reset: got %h, required %h", READDATA, model_rd); end
  endtask

  task automatic test_latency1();
    // Write then read on the single-cycle instance.
    @(negedge clk);
    wr1 = 1'b1; addr1 = 8'h44; wd1 = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    wr1 = 1'b0;
    repeat (2) @(negedge clk);
    rd1 = 1'b1; addr1 = 8'h44;
    @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (busy1 !== 1'b1) begin n_fail++; $display("FAIL lat1_busy: got %b, required 1", busy1); end
    n_checks++;
    if (rdata1 !== model_rd1) begin n_fail++; $display("FAIL lat1_early: got %h, required %h", rdata1, model_rd1); end
    @(posedge clk);
    @(negedge clk); #1;
    model_rd1 = 8'hC3;
    n_checks++;
    if (rdata1 !== model_rd1) begin n_fail++; $display("FAIL lat1_data: got %h, required %h", rdata1, model_rd1); end
    n_checks++;
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL lat1_done: got %b, required 0", busy1); end
    rd1 = 1'b0;
  endtask

  task automatic test_random();
    int hi;
    int op;
    logic [7:0] rlb, a, d;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      d  = 8'($urandom);
      if (op == 1 && written_q.size() > 0) begin
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        access(1'b1, 1'b0, a, d, hi, rlb);
        model_apply(1'b1, 1'b0, a, d);
      end else begin
        a = 8'($urandom);
        access(op == 2, 1'b1, a, d, hi, rlb);
        model_apply(op == 2, 1'b1, a, d);
      end
      n_checks++;
      if (hi != 6 || READDATA !== model_rd) begin
        n_fail++;
        $display("FAIL random_%0d: stall %0d data %h, required stall 6 data %h", i, hi, READDATA, model_rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int hi;
    logic [7:0] rlb;
    @(negedge clk);
    READ = 1'b1; ADDRESS = 8'h10;
    #1;
    run_until_done(1'b0, hi, rlb);
    model_apply(1'b1, 1'b0, 8'h10, 8'h00);
    n_checks++;
    if (READDATA !== model_rd) begin n_fail++; $display("FAIL b2b_first: got %h, required %h", READDATA, model_rd); end
    // Request stays high through DONE; it must wait for the IDLE cycle.
    ADDRESS = 8'h20;
    @(negedge clk); #1;
    run_until_done(1'b1, hi, rlb);
    model_apply(1'b1, 1'b0, 8'h20, 8'h00);
    n_checks++;
    if (hi != 6) begin n_fail++; $display("FAIL b2b_done_accept: got %0d cycles, required 6", hi); end
    n_checks++;
    if (READDATA !== model_rd) begin n_fail++; $display("FAIL b2b_second: got %h, required %h", READDATA, model_rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_both();
    test_mid_busy();
    test_reset_mid_write();
    test_clear_on_reset();
    test_latency1();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
